// File: rtl/ttt_board_ctrl.sv
// ttt_board_ctrl: tic-tac-toe game-state controller feeding vga_display
// Ports:
//   clk       : 100 MHz system clock
//   rst       : asynchronous reset, active-low
//   btn_up, btn_down, btn_left, btn_right, btn_place : debounced button levels, active-high
//   xi, oi    : X / O marks, bit n = cell n (row-major, cell 0 top-left)
//   cr        : one-hot cursor, all zero while go=1
//   go        : game over
//   turn      : 0 = X to move, 1 = O to move
//   winner    : 00 none, 01 X, 10 O, 11 draw
// Build option: define TTT_CURSOR_WRAP_EN to wrap the cursor at the grid edges
// instead of saturating there.
module ttt_board_ctrl #(
   parameter int GO_HOLD = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_place,
   output logic [8:0] xi,
   output logic [8:0] oi,
   output logic [8:0] cr,
   output logic       go,
   output logic       turn,
   output logic [1:0] winner
);
   localparam logic [1:0] S_PLAY  = 2'd0;
   localparam logic [1:0] S_CHECK = 2'd1;
   localparam logic [1:0] S_OVER  = 2'd2;
   localparam int CW = (GO_HOLD > 1) ? $clog2(GO_HOLD) : 1;
   localparam logic [CW-1:0] HOLD_MAX = CW'(GO_HOLD - 1);

   logic [1:0]    r_state;
   logic [4:0]    r_prev;
   logic [8:0]    r_xi, r_oi, r_cr;
   logic          r_go, r_turn;
   logic [1:0]    r_winner;
   logic [CW-1:0] r_cnt;

   logic [4:0] w_btn, w_ev;
   logic       w_row0, w_row2, w_col0, w_col2;
   logic [8:0] w_up, w_down, w_left, w_right, w_mark;
   logic       w_win, w_full, w_empty, w_sat;

   // event vector ordered {place, up, down, left, right}
   assign w_btn = {btn_place, btn_up, btn_down, btn_left, btn_right};
   assign w_ev  = w_btn & ~r_prev;

   assign w_row0 = |r_cr[2:0];
   assign w_row2 = |r_cr[8:6];
   assign w_col0 = r_cr[0] | r_cr[3] | r_cr[6];
   assign w_col2 = r_cr[2] | r_cr[5] | r_cr[8];

   // one-hot cursor moves: a row step is a shift by 3, a column step by 1
`ifdef TTT_CURSOR_WRAP_EN
   assign w_up    = w_row0 ? r_cr << 6 : r_cr >> 3;
   assign w_down  = w_row2 ? r_cr >> 6 : r_cr << 3;
   assign w_left  = w_col0 ? r_cr << 2 : r_cr >> 1;
   assign w_right = w_col2 ? r_cr >> 2 : r_cr << 1;
`else
   assign w_up    = w_row0 ? r_cr : r_cr >> 3;
   assign w_down  = w_row2 ? r_cr : r_cr << 3;
   assign w_left  = w_col0 ? r_cr : r_cr >> 1;
   assign w_right = w_col2 ? r_cr : r_cr << 1;
`endif

   // turn has not toggled yet in CHECK, so it still names the player who just moved
   assign w_mark  = r_turn ? r_oi : r_xi;
   assign w_win   = (&w_mark[2:0]) | (&w_mark[5:3]) | (&w_mark[8:6]) |
                    (w_mark[0] & w_mark[3] & w_mark[6]) |
                    (w_mark[1] & w_mark[4] & w_mark[7]) |
                    (w_mark[2] & w_mark[5] & w_mark[8]) |
                    (w_mark[0] & w_mark[4] & w_mark[8]) |
                    (w_mark[2] & w_mark[4] & w_mark[6]);
   assign w_full  = &(r_xi | r_oi);
   assign w_empty = ((r_xi | r_oi) & r_cr) == 9'd0;
   assign w_sat   = r_cnt == HOLD_MAX;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_PLAY;
         r_prev   <= '0;
         r_xi     <= '0;
         r_oi     <= '0;
         r_cr     <= 9'h010;
         r_go     <= 1'b0;
         r_turn   <= 1'b0;
         r_winner <= 2'b00;
         r_cnt    <= '0;
      end else begin
         // prev always tracks the buttons so events in CHECK/OVER are consumed
         r_prev <= w_btn;
         case (r_state)
            S_PLAY: begin
               if (w_ev[4]) begin
                  if (w_empty) begin
                     if (r_turn) r_oi <= r_oi | r_cr;
                     else r_xi <= r_xi | r_cr;
                     r_state <= S_CHECK;
                  end
               end else if (w_ev[3]) r_cr <= w_up;
               else if (w_ev[2]) r_cr <= w_down;
               else if (w_ev[1]) r_cr <= w_left;
               else if (w_ev[0]) r_cr <= w_right;
            end
            S_CHECK: begin
               if (w_win || w_full) begin
                  r_winner <= w_win ? (r_turn ? 2'b10 : 2'b01) : 2'b11;
                  r_go     <= 1'b1;
                  r_cr     <= '0;
                  r_cnt    <= '0;
                  r_state  <= S_OVER;
               end else begin
                  r_turn  <= ~r_turn;
                  r_state <= S_PLAY;
               end
            end
            S_OVER: begin
               if (w_ev[4] && w_sat) begin
                  r_xi     <= '0;
                  r_oi     <= '0;
                  r_cr     <= 9'h010;
                  r_turn   <= 1'b0;
                  r_winner <= 2'b00;
                  r_go     <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= S_PLAY;
               end else if (!w_sat) r_cnt <= r_cnt + 1'b1;
            end
            default: r_state <= S_PLAY;
         endcase
      end
   end

   assign xi     = r_xi;
   assign oi     = r_oi;
   assign cr     = r_cr;
   assign go     = r_go;
   assign turn   = r_turn;
   assign winner = r_winner;
endmodule

// File: tb/tb_ttt_board_ctrl.sv
// tb_ttt_board_ctrl: scoreboard bench for ttt_board_ctrl with GO_HOLD=16
module tb_ttt_board_ctrl;
`ifdef TTT_CURSOR_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif
   localparam int UP = 3, DN = 2, LT = 1, RT = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_place = 1'b0;
   logic [8:0] xi, oi, cr;
   logic go, turn;
   logic [1:0] winner;

   always #5 clk = ~clk;

   ttt_board_ctrl #(.GO_HOLD(16)) dut (
      .clk(clk), .rst(rst),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .btn_place(btn_place),
      .xi(xi), .oi(oi), .cr(cr), .go(go), .turn(turn), .winner(winner)
   );

   typedef struct {
      string      tag;
      logic [8:0] xi, oi, cr;
      logic       go, turn;
      logic [1:0] win;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0, n_errors = 0;
   int pos = 4;
   logic [8:0] e_xi, e_oi, e_cr;
   logic e_go, e_turn;
   logic [1:0] e_win;

   task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input string tag);
      exp_t e;
      e.tag = tag; e.xi = e_xi; e.oi = e_oi; e.cr = e_cr;
      e.go = e_go; e.turn = e_turn; e.win = e_win;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".xi"}, xi, e.xi);
      chk({e.tag, ".oi"}, oi, e.oi);
      chk({e.tag, ".cr"}, cr, e.cr);
      chk({e.tag, ".go"}, 9'(go), 9'(e.go));
      chk({e.tag, ".turn"}, 9'(turn), 9'(e.turn));
      chk({e.tag, ".winner"}, 9'(winner), 9'(e.win));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_btn(input logic [4:0] b);
      {btn_place, btn_up, btn_down, btn_left, btn_right} = b;
   endtask

   task automatic reset_exp();
      e_xi = '0; e_oi = '0; e_cr = 9'h010; e_go = 1'b0; e_turn = 1'b0; e_win = 2'b00;
      pos = 4;
   endtask

   // two expectations are queued per press: after the press edge and one edge later
   task automatic do_press(input logic [4:0] b);
      set_btn(b);
      tick();
      pop_check();
      set_btn(5'b0);
      tick();
      pop_check();
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      #2;
      reset_exp();
      push_exp(tag);
      pop_check();
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic mv(input int dir, input string tag);
      int r = pos / 3;
      int c = pos % 3;
      case (dir)
         UP:      r = (r == 0) ? (WRAP ? 2 : 0) : r - 1;
         DN:      r = (r == 2) ? (WRAP ? 0 : 2) : r + 1;
         LT:      c = (c == 0) ? (WRAP ? 2 : 0) : c - 1;
         default: c = (c == 2) ? (WRAP ? 0 : 2) : c + 1;
      endcase
      pos = r * 3 + c;
      e_cr = 9'(1 << pos);
      push_exp(tag);
      push_exp(tag);
      do_press(5'(1 << dir));
   endtask

   task automatic goto(input int t);
      while (pos / 3 > t / 3) mv(UP, "goto");
      while (pos / 3 < t / 3) mv(DN, "goto");
      while (pos % 3 > t % 3) mv(LT, "goto");
      while (pos % 3 < t % 3) mv(RT, "goto");
   endtask

   // res: outcome after CHECK (00 play on, 01/10 win, 11 draw)
   task automatic place(input logic [4:0] b, input logic [1:0] res, input string tag);
      logic [8:0] m = 9'(1 << pos);
      if (((e_xi | e_oi) & m) == 9'd0) begin
         if (e_turn) e_oi = e_oi | m;
         else e_xi = e_xi | m;
         push_exp(tag);
         if (res != 2'b00) begin
            e_go = 1'b1; e_cr = '0; e_win = res;
         end else e_turn = ~e_turn;
         push_exp(tag);
      end else begin
         push_exp(tag);
         push_exp(tag);
      end
      do_press(b);
   endtask

   task automatic idle_press(input logic [4:0] b, input string tag);
      push_exp(tag);
      push_exp(tag);
      do_press(b);
   endtask

   int win_seq[5] = '{0, 3, 1, 4, 2};
   int draw_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

   initial begin
      #1;
      do_reset("reset");
      // cursor moves and edge behaviour
      mv(RT, "t1_right");
      mv(DN, "t1_down");
      mv(RT, "t1_edge_right");
      // rejected placement keeps turn
      goto(4);
      place(5'b10000, 2'b00, "t2_x4");
      place(5'b10000, 2'b00, "t2_o4_rejected");
      goto(0);
      place(5'b10000, 2'b00, "t2_o0");
      do_reset("reset_midgame");
      // X wins on the top row
      for (int i = 0; i < 5; i++) begin
         goto(win_seq[i]);
         place(5'b10000, (i == 4) ? 2'b01 : 2'b00, "t3_win");
      end
      // hold counter is 0 here; place at 5 ignored, moves ignored, place at 14 ignored
      repeat (5) tick();
      idle_press(5'b10000, "t5_place_cnt5");
      idle_press(5'b01000, "t5_up_over");
      repeat (5) tick();
      idle_press(5'b10000, "t5_place_cnt14");
      reset_exp();
      idle_press(5'b10000, "t5_restart");
      // simultaneous place+left: place wins; a right rising during CHECK is consumed
      e_xi = 9'h010;
      push_exp("t6_place_left");
      set_btn(5'b10010);
      tick();
      pop_check();
      e_turn = 1'b1;
      push_exp("t6_check_right");
      set_btn(5'b00001);
      tick();
      pop_check();
      push_exp("t6_right_held");
      tick();
      pop_check();
      set_btn(5'b0);
      tick();
      do_reset("reset_pre_draw");
      // full board, no line
      for (int i = 0; i < 9; i++) begin
         goto(draw_seq[i]);
         place(5'b10000, (i == 8) ? 2'b11 : 2'b00, "t4_draw");
      end
      repeat (3) tick();
      do_reset("reset_mid_over");
      // button already high at reset release fires once on the first edge
      rst = 1'b0;
      set_btn(5'b00001);
      tick();
      rst = 1'b1;
      e_cr = 9'h020;
      push_exp("rst_held_right");
      tick();
      pop_check();
      push_exp("rst_held_right_hold");
      tick();
      pop_check();
      set_btn(5'b0);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
